// File: rtl/echo_queue.sv
// Echo block: DEPTH-entry request FIFO feeding a one-entry delay register that answers on indication_heard.
// Optional response counter output heard_count enabled by defining ECHO_QUEUE_COUNT_EN.
module echo_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      request_say__ENA,
  input  logic [DATA_WIDTH-1:0]     request_say_meth,
  input  logic [DATA_WIDTH-1:0]     request_say_v,
  output logic                      request_say__RDY,
  input  logic                      request_say2__ENA,
  input  logic [DATA_WIDTH-1:0]     request_say2_meth,
  input  logic [DATA_WIDTH-1:0]     request_say2_v,
  output logic                      request_say2__RDY,
  output logic                      indication_heard__ENA,
  output logic [DATA_WIDTH-1:0]     indication_heard_meth,
  output logic [DATA_WIDTH-1:0]     indication_heard_v,
  input  logic                      indication_heard__RDY,
  input  logic [1:0]                rule_enable,
  output logic [1:0]                rule_ready,
  output logic [$clog2(DEPTH):0]    occupancy
`ifdef ECHO_QUEUE_COUNT_EN
  ,
  output logic [31:0]               heard_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = 2 * DATA_WIDTH;

  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          busy_delay;
  logic [MW-1:0] delay_q;

  logic          full;
  logic          empty;
  logic          say_fire;
  logic          say2_fire;
  logic          enq;
  logic [MW-1:0] enq_data;
  logic          delay_ready;
  logic          respond_ready;
  logic          pop;
  logic          respond_fire;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Ready signals depend only on registered state plus the listed inputs.
  always_comb begin
    request_say__RDY  = !full;
    request_say2__RDY = !full && !request_say__ENA;
    say_fire          = request_say__ENA && request_say__RDY;
    say2_fire         = request_say2__ENA && request_say2__RDY;
    enq               = say_fire || say2_fire;
    enq_data          = say_fire ? {request_say_meth, request_say_v}
                                 : {request_say2_meth, request_say2_v};
  end

  always_comb begin
    respond_ready = busy_delay && indication_heard__RDY;
    delay_ready   = !empty && (!busy_delay || respond_ready);
    respond_fire  = respond_ready && rule_enable[1];
    pop           = delay_ready && rule_enable[0];
    rule_ready    = {respond_ready, delay_ready};
  end

  assign indication_heard__ENA = respond_fire;
  assign indication_heard_meth = delay_q[MW-1:DATA_WIDTH];
  assign indication_heard_v    = delay_q[DATA_WIDTH-1:0];
  assign occupancy             = count;

  // Storage array is left unreset; pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_delay <= 1'b0;
      delay_q    <= '0;
    end else if (pop) begin
      busy_delay <= 1'b1;
      delay_q    <= mem[rd_ptr];
    end else if (respond_fire) begin
      busy_delay <= 1'b0;
    end
  end

`ifdef ECHO_QUEUE_COUNT_EN
  logic [31:0] heard_count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)             heard_count_q <= '0;
    else if (respond_fire) heard_count_q <= heard_count_q + 32'd1;
  end

  assign heard_count = heard_count_q;
`endif

endmodule

// File: tb/tb_echo_queue.sv
// Self-checking bench for echo_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_echo_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          say_en, say2_en, heard_rdy;
  logic [W-1:0]  say_meth, say_v, say2_meth, say2_v;
  logic          say_rdy, say2_rdy, heard_ena;
  logic [W-1:0]  heard_meth, heard_v;
  logic [1:0]    rule_en, rule_rdy;
  logic [OW-1:0] occ;
`ifdef ECHO_QUEUE_COUNT_EN
  logic [31:0]   heard_count;
`endif

  echo_queue #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .request_say__ENA      (say_en),
    .request_say_meth      (say_meth),
    .request_say_v         (say_v),
    .request_say__RDY      (say_rdy),
    .request_say2__ENA     (say2_en),
    .request_say2_meth     (say2_meth),
    .request_say2_v        (say2_v),
    .request_say2__RDY     (say2_rdy),
    .indication_heard__ENA (heard_ena),
    .indication_heard_meth (heard_meth),
    .indication_heard_v    (heard_v),
    .indication_heard__RDY (heard_rdy),
    .rule_enable           (rule_en),
    .rule_ready            (rule_rdy),
    .occupancy             (occ)
`ifdef ECHO_QUEUE_COUNT_EN
    ,
    .heard_count           (heard_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO as a queue of {meth, v}, plus the delay slot.
  logic [2*W-1:0] fifo_m [$];
  bit             dvalid_m;
  logic [2*W-1:0] ddata_m;
  logic [31:0]    cnt_m;

  // Observations from the most recent step.
  logic           l_ena, l_srdy, l_s2rdy;
  logic [W-1:0]   l_meth, l_v;
  logic [1:0]     l_rr;
  logic [OW-1:0]  l_occ;
  logic [W-1:0]   log_meth [$];
  logic [W-1:0]   log_v [$];
  int             log_cyc [$];
  int             cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    fifo_m.delete();
    dvalid_m = 1'b0;
    ddata_m  = '0;
    cnt_m    = '0;
  endfunction

  task automatic step(input bit s, input logic [W-1:0] sm, input logic [W-1:0] sv,
                      input bit s2, input logic [W-1:0] s2m, input logic [W-1:0] s2v,
                      input bit hr, input logic [1:0] re);
    bit full, empty, e_srdy, e_s2rdy, resp_rdy, dly_rdy, e_ena, do_pop;
    logic [2*W-1:0] popped;
    @(negedge CLK);
    say_en = s;  say_meth = sm;  say_v = sv;
    say2_en = s2; say2_meth = s2m; say2_v = s2v;
    heard_rdy = hr; rule_en = re;
    #1;
    full     = (fifo_m.size() == DEPTH);
    empty    = (fifo_m.size() == 0);
    e_srdy   = !full;
    e_s2rdy  = !full && !s;
    resp_rdy = dvalid_m && hr;
    dly_rdy  = !empty && (!dvalid_m || resp_rdy);
    e_ena    = resp_rdy && re[1];
    do_pop   = dly_rdy && re[0];
    chk("say_rdy",    64'(say_rdy),    64'(e_srdy));
    chk("say2_rdy",   64'(say2_rdy),   64'(e_s2rdy));
    chk("heard_ena",  64'(heard_ena),  64'(e_ena));
    chk("heard_meth", 64'(heard_meth), 64'(ddata_m[2*W-1:W]));
    chk("heard_v",    64'(heard_v),    64'(ddata_m[W-1:0]));
    chk("rule_ready", 64'(rule_rdy),   64'({resp_rdy, dly_rdy}));
    chk("occupancy",  64'(occ),        64'(fifo_m.size()));
`ifdef ECHO_QUEUE_COUNT_EN
    chk("heard_count", 64'(heard_count), 64'(cnt_m));
`endif
    l_ena = heard_ena; l_meth = heard_meth; l_v = heard_v;
    l_srdy = say_rdy; l_s2rdy = say2_rdy; l_rr = rule_rdy; l_occ = occ;
    if (heard_ena) begin
      log_meth.push_back(heard_meth);
      log_v.push_back(heard_v);
      log_cyc.push_back(cyc);
    end
    // Advance the model to the state after the coming edge.
    if (e_ena) cnt_m = cnt_m + 32'd1;
    if (do_pop) begin
      popped   = fifo_m.pop_front();
      ddata_m  = popped;
      dvalid_m = 1'b1;
    end else if (e_ena) begin
      dvalid_m = 1'b0;
    end
    if (s && e_srdy)        fifo_m.push_back({sm, sv});
    else if (s2 && e_s2rdy) fifo_m.push_back({s2m, s2v});
    cyc++;
  endtask

  task automatic idle(input int n, input bit hr);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, hr, 2'b11);
  endtask

  task automatic say(input logic [W-1:0] m, input logic [W-1:0] v, input bit hr);
    step(1, m, v, 0, '0, '0, hr, 2'b11);
  endtask

  task automatic clear_log();
    log_meth.delete(); log_v.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    say_en = 0; say2_en = 0; heard_rdy = 0; rule_en = 2'b00;
    say_meth = '0; say_v = '0; say2_meth = '0; say2_v = '0;
    model_reset();
    #1;
    chk("rst_say_rdy",    64'(say_rdy),    64'd1);
    chk("rst_say2_rdy",   64'(say2_rdy),   64'd1);
    chk("rst_heard_ena",  64'(heard_ena),  64'd0);
    chk("rst_heard_v",    64'(heard_v),    64'd0);
    chk("rst_heard_meth", 64'(heard_meth), 64'd0);
    chk("rst_rule_ready", 64'(rule_rdy),   64'd0);
    chk("rst_occupancy",  64'(occ),        64'd0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    int bad;
    int r;
    bit s, s2;
    nRST = 1'b0;
    say_en = 0; say2_en = 0; heard_rdy = 0; rule_en = 2'b00;
    say_meth = '0; say_v = '0; say2_meth = '0; say2_v = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    do_reset();

    // Single message: response two cycles after acceptance.
    clear_log();
    say(32'd5, 32'h1234, 1);
    idle(1, 1);
    chk("lat_n1_ena", 64'(l_ena), 64'd0);
    idle(1, 1);
    chk("lat_n2_ena",  64'(l_ena),  64'd1);
    chk("lat_n2_meth", 64'(l_meth), 64'd5);
    chk("lat_n2_v",    64'(l_v),    64'h1234);
    chk("lat_n2_occ",  64'(l_occ),  64'd0);
    idle(2, 1);
    chk("lat_count", 64'(log_v.size()), 64'd1);

    // say has priority over say2.
    clear_log();
    step(1, 32'd1, 32'hA, 1, 32'd2, 32'hB, 1, 2'b11);
    chk("prio_s2rdy", 64'(l_s2rdy), 64'd0);
    step(0, '0, '0, 1, 32'd2, 32'hB, 1, 2'b11);
    chk("prio_s2rdy_next", 64'(l_s2rdy), 64'd1);
    idle(4, 1);
    chk("prio_count", 64'(log_meth.size()), 64'd2);
    if (log_meth.size() == 2) begin
      chk("prio_first",  64'(log_meth[0]), 64'd1);
      chk("prio_second", 64'(log_meth[1]), 64'd2);
    end

    // Backpressure: fill FIFO and delay register, then release.
    clear_log();
    for (int i = 0; i < 6; i++) say(32'd10 + 32'(i), 32'(i), 0);
    idle(1, 0);
    chk("bp_occ",    64'(l_occ),   64'd4);
    chk("bp_srdy",   64'(l_srdy),  64'd0);
    chk("bp_s2rdy",  64'(l_s2rdy), 64'd0);
    chk("bp_no_ena", 64'(log_v.size()), 64'd0);
    idle(7, 1);
    chk("bp_count", 64'(log_v.size()), 64'd5);
    bad = 0;
    for (int k = 0; k < log_v.size(); k++) begin
      if (log_v[k] != 32'(k)) bad++;
      if (k > 0 && log_cyc[k] != log_cyc[k-1] + 1) bad++;
    end
    chk("bp_order_contig", 64'(bad), 64'd0);

    // 100 back-to-back messages: continuous responses, pointer wrap.
    clear_log();
    r = cyc;
    for (int i = 0; i < 104; i++) begin
      if (i < 100) say(32'd7, 32'(i), 1);
      else idle(1, 1);
    end
    chk("burst_count", 64'(log_v.size()), 64'd100);
    bad = 0;
    for (int k = 0; k < log_v.size(); k++)
      if (log_v[k] != 32'(k) || log_cyc[k] != r + k + 2) bad++;
    chk("burst_order_timing", 64'(bad), 64'd0);

    // Asynchronous reset with messages in flight.
    for (int i = 0; i < 3; i++) say(32'd3, 32'(100 + i), 0);
    @(negedge CLK);
    heard_rdy = 1; rule_en = 2'b11; say_en = 0; say2_en = 0;
    #1;
    chk("arst_pre_ena", 64'(heard_ena), 64'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_ena", 64'(heard_ena), 64'd0);
    chk("arst_occ", 64'(occ),       64'd0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    clear_log();
    say(32'd9, 32'h55, 1);
    idle(5, 1);
    chk("arst_one_resp", 64'(log_v.size()), 64'd1);

`ifdef ECHO_QUEUE_COUNT_EN
    do_reset();
    for (int i = 0; i < 7; i++) say(32'd1, 32'(i), 1);
    idle(3, 1);
    chk("cnt_seven", 64'(heard_count), 64'd7);
    @(negedge CLK);
    force dut.heard_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.heard_count_q;
    cnt_m = 32'hFFFF_FFFF;
    say(32'd1, 32'd8, 1);
    idle(3, 1);
    chk("cnt_wrap", 64'(heard_count), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 7);
      s  = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 2) == 0);
      step(s, $urandom, $urandom, s2, $urandom, $urandom,
           ($urandom_range(0, 3) != 0), (r < 5) ? 2'b11 : 2'(r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
